// File: rtl/mult_div_unit.sv
// mult_div_unit: iterative signed 32x32 multiply (radix-2 Booth) and
// signed divide (restoring, on magnitudes) writing a HI/LO register pair.
// Ports: clk, reset (sync, active low), start/op/a/b request,
//   busy/done/div_zero status, hi/lo results.
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  typedef enum logic [1:0] {
    IDLE,
    MULT,
    DIV,
    DONE
  } state_t;

  localparam logic [5:0] LAST = 6'(WIDTH);

  state_t           state;
  logic [5:0]       count;
  logic [WIDTH:0]   acc;
  logic [WIDTH-1:0] qReg;
  logic [WIDTH-1:0] mReg;
  logic             qm1;
  logic             negQ;
  logic             negR;
  logic             zeroDiv;

  logic [WIDTH:0]   mExt;
  logic [WIDTH:0]   boothSum;
  logic [WIDTH:0]   divShift;
  logic [WIDTH+1:0] divTrial;
  logic [WIDTH-1:0] absA;
  logic [WIDTH-1:0] absB;
  logic [WIDTH-1:0] quoFix;
  logic [WIDTH-1:0] remFix;

  assign absA = a[WIDTH-1] ? ~a + 1'b1 : a;
  assign absB = b[WIDTH-1] ? ~b + 1'b1 : b;
  assign quoFix = negQ ? ~qReg + 1'b1 : qReg;
  assign remFix = negR ? ~acc[WIDTH-1:0] + 1'b1
                       : acc[WIDTH-1:0];

  // Accumulator carries one guard bit so that subtracting the most
  // negative multiplicand cannot overflow.
  assign mExt = {mReg[WIDTH-1], mReg};

  always_comb begin
    boothSum = acc;
    unique case ({qReg[0], qm1})
      2'b01:   boothSum = acc + mExt;
      2'b10:   boothSum = acc - mExt;
      default: boothSum = acc;
    endcase
  end

  // Remainder shifts left taking the next dividend bit from qReg,
  // which fills with quotient bits from the bottom.
  assign divShift = {acc[WIDTH-1:0], qReg[WIDTH-1]};
  assign divTrial = {1'b0, divShift} - {2'b00, mReg};

  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= IDLE;
      count    <= '0;
      acc      <= '0;
      qReg     <= '0;
      mReg     <= '0;
      qm1      <= 1'b0;
      negQ     <= 1'b0;
      negR     <= 1'b0;
      zeroDiv  <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      div_zero <= 1'b0;
      hi       <= '0;
      lo       <= '0;
    end else begin
      done     <= 1'b0;
      div_zero <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            count <= '0;
            acc   <= '0;
            qm1   <= 1'b0;
            busy  <= 1'b1;
            if (!op) begin
              mReg    <= a;
              qReg    <= b;
              negQ    <= 1'b0;
              negR    <= 1'b0;
              zeroDiv <= 1'b0;
              state   <= MULT;
            end else begin
              mReg    <= absB;
              qReg    <= absA;
              negQ    <= a[WIDTH-1] ^ b[WIDTH-1];
              negR    <= a[WIDTH-1];
              zeroDiv <= (b == '0);
              state   <= DIV;
            end
          end
        end
        MULT: begin
          if (count == LAST) begin
            hi    <= acc[WIDTH-1:0];
            lo    <= qReg;
            done  <= 1'b1;
            state <= DONE;
          end else begin
            acc   <= {boothSum[WIDTH], boothSum[WIDTH:1]};
            qReg  <= {boothSum[0], qReg[WIDTH-1:1]};
            qm1   <= qReg[0];
            count <= count + 6'd1;
          end
        end
        DIV: begin
          // A zero divisor spends one cycle here and leaves hi/lo alone.
          if (zeroDiv) begin
            done     <= 1'b1;
            div_zero <= 1'b1;
            state    <= DONE;
          end else if (count == LAST) begin
            hi    <= remFix;
            lo    <= quoFix;
            done  <= 1'b1;
            state <= DONE;
          end else begin
            if (!divTrial[WIDTH+1]) begin
              acc  <= divTrial[WIDTH:0];
              qReg <= {qReg[WIDTH-2:0], 1'b1};
            end else begin
              acc  <= divShift;
              qReg <= {qReg[WIDTH-2:0], 1'b0};
            end
            count <= count + 6'd1;
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit: directed checks of mult_div_unit results,
// latency, busy/done/div_zero behaviour and reset.
module tb_mult_div_unit;

  logic        clk;
  logic        reset;
  logic        start;
  logic        op;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic        div_zero;
  logic [31:0] hi;
  logic [31:0] lo;

  int checks = 0;
  int fails = 0;

  mult_div_unit #(.WIDTH(32)) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .op(op),
    .a(a),
    .b(b),
    .busy(busy),
    .done(done),
    .div_zero(div_zero),
    .hi(hi),
    .lo(lo)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Issue one operation at the next edge (E0), scramble the inputs,
  // then check busy, the single done pulse after E33 (or E1 for a
  // zero divisor), the results and the return to idle.
  task automatic runOp(input logic o,
                       input logic [31:0] x,
                       input logic [31:0] y,
                       input logic [31:0] eh,
                       input logic [31:0] el,
                       input logic ed,
                       input bit pokeDone,
                       input string tag);
    int lat;
    int busyLow;
    int doneEarly;
    lat = (o && y == 32'd0) ? 1 : 33;
    busyLow = 0;
    doneEarly = 0;
    start = 1'b1;
    op = o;
    a = x;
    b = y;
    step();
    start = 1'b0;
    op = ~o;
    a = $urandom;
    b = $urandom;
    for (int i = 0; i < lat; i++) begin
      if (!busy) busyLow++;
      if (done || div_zero) doneEarly++;
      step();
    end
    chk({tag, " busyRun"}, 64'(busyLow), 64'd0);
    chk({tag, " earlyDone"}, 64'(doneEarly), 64'd0);
    chk({tag, " done"}, 64'(done), 64'd1);
    chk({tag, " divZero"}, 64'(div_zero), 64'(ed));
    chk({tag, " busyDone"}, 64'(busy), 64'd1);
    chk({tag, " hi"}, 64'(hi), 64'(eh));
    chk({tag, " lo"}, 64'(lo), 64'(el));
    if (pokeDone) begin
      start = 1'b1;
      op = 1'b0;
      a = 32'd1;
      b = 32'd1;
    end
    step();
    start = 1'b0;
    chk({tag, " doneAfter"}, 64'(done), 64'd0);
    chk({tag, " dzAfter"}, 64'(div_zero), 64'd0);
    chk({tag, " busyAfter"}, 64'(busy), 64'd0);
  endtask

  initial begin
    int doneCnt;
    int busyCnt;
    int doneAt;
    logic [31:0] hiS;
    logic [31:0] loS;

    reset = 1'b0;
    start = 1'b0;
    op = 1'b0;
    a = '0;
    b = '0;
    step();
    step();
    reset = 1'b1;
    chk("rst busy", 64'(busy), 64'd0);
    chk("rst done", 64'(done), 64'd0);
    chk("rst dz", 64'(div_zero), 64'd0);
    chk("rst hi", 64'(hi), 64'd0);
    chk("rst lo", 64'(lo), 64'd0);

    runOp(1'b0, 32'd7, 32'hFFFF_FFFD,
          32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, 1'b0, "mul7xm3");
    runOp(1'b0, 32'h8000_0000, 32'h8000_0000,
          32'h4000_0000, 32'h0000_0000, 1'b0, 1'b0, "mulMin");
    runOp(1'b1, 32'hFFFF_FFF9, 32'd2,
          32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 1'b0, "divm7by2");
    runOp(1'b1, 32'h8000_0000, 32'hFFFF_FFFF,
          32'h0000_0000, 32'h8000_0000, 1'b0, 1'b0, "divMinByM1");
    runOp(1'b1, 32'd7, 32'hFFFF_FFFE,
          32'h0000_0001, 32'hFFFF_FFFD, 1'b0, 1'b0, "div7bym2");

    // Load a distinctive hi/lo pair, then divide by zero over it.
    runOp(1'b0, 32'h1234_5678, 32'h7FFF_FFFF,
          32'h091A_2B3B, 32'hEDCB_A988, 1'b0, 1'b0, "mulPreload");
    runOp(1'b1, 32'd5, 32'd0,
          32'h091A_2B3B, 32'hEDCB_A988, 1'b1, 1'b0, "divZero");

    // Reset in cycle 10 of a multiply.
    start = 1'b1;
    op = 1'b0;
    a = 32'd9;
    b = 32'd9;
    step();
    start = 1'b0;
    repeat (9) step();
    reset = 1'b0;
    step();
    reset = 1'b1;
    chk("abort busy", 64'(busy), 64'd0);
    chk("abort done", 64'(done), 64'd0);
    chk("abort hi", 64'(hi), 64'd0);
    chk("abort lo", 64'(lo), 64'd0);
    doneCnt = 0;
    busyCnt = 0;
    repeat (40) begin
      if (done) doneCnt++;
      if (busy) busyCnt++;
      step();
    end
    chk("abort noDone", 64'(doneCnt), 64'd0);
    chk("abort noBusy", 64'(busyCnt), 64'd0);
    chk("abort hiHeld", 64'(hi), 64'd0);

    // start during DONE is dropped; the next op runs back-to-back.
    runOp(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
          32'h0000_0000, 32'h0000_0001, 1'b0, 1'b1, "mulM1poke");
    runOp(1'b0, 32'd3, 32'd5,
          32'h0000_0000, 32'd15, 1'b0, 1'b0, "mul3x5");

    // A second start while the divide runs must be ignored.
    start = 1'b1;
    op = 1'b1;
    a = 32'd100;
    b = 32'd7;
    step();
    doneCnt = 0;
    doneAt = -1;
    hiS = '0;
    loS = '0;
    for (int i = 0; i < 40; i++) begin
      if (done) begin
        doneCnt++;
        if (doneAt < 0) doneAt = i;
        hiS = hi;
        loS = lo;
      end
      if (i >= 4 && i < 8) begin
        start = 1'b1;
        op = 1'b0;
        a = 32'd3;
        b = 32'd3;
      end else begin
        start = 1'b0;
      end
      step();
    end
    start = 1'b0;
    chk("busyStart doneCnt", 64'(doneCnt), 64'd1);
    chk("busyStart doneAt", 64'(doneAt), 64'd33);
    chk("busyStart lo", 64'(loS), 64'd14);
    chk("busyStart hi", 64'(hiS), 64'd2);
    chk("busyStart idle", 64'(busy), 64'd0);

    // Reset wins over start on the same edge.
    reset = 1'b0;
    start = 1'b1;
    op = 1'b0;
    a = 32'd2;
    b = 32'd2;
    step();
    reset = 1'b1;
    start = 1'b0;
    chk("rstPrio busy", 64'(busy), 64'd0);
    step();
    chk("rstPrio busy2", 64'(busy), 64'd0);
    chk("rstPrio lo", 64'(lo), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, fails);
    $finish;
  end

endmodule
